vga_io_port_arbiter: RTL
========================

# vga_io_port_arbiter

Shares the single main-clock I/O port of the VGA memory system between the CPU and an internal fill/copy engine, so that text-mode screen clears and scrolls run in hardware while the CPU keeps access. The block sits between the CPU bus decode and the VGA memory system's `io_*` port, entirely in the `main_clk` domain. It arbitrates per access, tracks the port's two-cycle read latency, and sequences word-granular fill and ascending copy commands.

## Interface
- No parameters.
- `main_clk  in  1` System clock.
- `reset_n  in  1` Reset: asynchronous, active-low.
- `cpu_req  in  1` CPU access request. Held high until `cpu_ack`.
- `cpu_write  in  1` 1 = write, 0 = read. Stable while `cpu_req` is high.
- `cpu_byte_op  in  1` Byte access. Passed through to memory.
- `cpu_addr  in  15` CPU byte address.
- `cpu_wdata  in  16` CPU write data.
- `cpu_rdata  out  16` Read data. Valid only in the `cpu_ack` cycle of a read.
- `cpu_ack  out  1` One-cycle completion pulse.
- `cmd_valid  in  1` Engine command offer.
- `cmd_ready  out  1` Engine idle; command is accepted when `cmd_valid & cmd_ready`.
- `cmd_copy  in  1` 0 = fill, 1 = copy.
- `cmd_src  in  15` Copy source byte address. Bit 0 is ignored (word aligned).
- `cmd_dst  in  15` Destination byte address. Bit 0 is ignored.
- `cmd_len  in  14` Number of 16-bit words to process.
- `cmd_fill_data  in  16` Fill word.
- `busy  out  1` Engine is running a command.
- `done  out  1` One-cycle pulse when a command completes.
- `mem_do_write  out  1` To the memory system's `io_do_write`.
- `mem_do_byte_op  out  1` To `io_do_byte_op`.
- `mem_addr  out  15` To `io_addr`.
- `mem_write_data  out  16` To `io_write_data`.
- `mem_read_data  in  16` From `io_read_data`. Returns data for the address presented 2 cycles earlier.

## Operation
**Port mux**
- The `mem_*` outputs are combinational from the current grant.
- With no grant, all `mem_*` outputs are 0. Address 0 read is harmless.
- Engine accesses are always word accesses: `mem_do_byte_op` = 0 and `mem_addr[0]` = 0.

**Arbitration**
- Each cycle at most one requester is granted: the CPU, or the engine while it is in FILL, C_RD or C_WR.
- The CPU is eligible only when `cpu_req` is high and no CPU access is in flight.
- If both are eligible, the one that was not granted last wins. A 1-bit round-robin pointer handles this; its reset value favours the CPU.
- If only one is eligible, it is granted.

**CPU accesses**
- A CPU read granted at cycle t is in flight during t+1 and t+2.
- The in-flight state suppresses re-granting on the still-high `cpu_req`.
- Byte reads at 20478 (frame counter) need no special handling here; they pass through unchanged.

**Engine states**
- IDLE: `cmd_ready` = 1.
  - On accept, latch `src`, `dst`, `len` and the fill word.
  - `len` = 0 → go to FIN.
  - Fill → FILL; copy → C_RD.
- FILL: request a write of the fill word to `dst`.
  - On grant: `dst += 2`, `len -= 1`.
  - Exit to FIN when the remaining count reaches 0.
- C_RD: request a read of `src`. On grant → C_W1.
- C_W1 → C_W2 unconditionally.
- C_W2: capture `mem_read_data` into the copy holding register → C_WR.
- C_WR: request a write of the holding register to `dst`.
  - On grant: `src += 2`, `dst += 2`, `len -= 1`.
  - Next state is FIN if the remaining count reaches 0, else C_RD.
- FIN: pulse `done` → IDLE.

**Arithmetic and ordering**
- Address increments wrap modulo 2^15.
- Copy is strictly ascending. An overlapping copy is correct when `dst` ≤ `src` (the scroll-up case); other overlaps are undefined.
- CPU writes that land inside an active command region are not ordered against the engine; software avoids them.

## Timing
**Reset values**
- `cpu_ack` = 0, `cpu_rdata` = 0, `busy` = 0, `done` = 0, `cmd_ready` = 1.
- All `mem_*` outputs = 0.
- State = IDLE, round-robin pointer favours the CPU.
- Reset asserted mid-command abandons the command: no `done`. Any in-flight CPU read is dropped and no ack is issued.

**Handshake timing**
- CPU write granted at t: `cpu_ack` at t+1.
- CPU read granted at t: `cpu_ack` at t+2, with `cpu_rdata` = `mem_read_data` (combinational pass-through) in that cycle.
- `busy` rises the cycle after accept and falls in the same cycle `done` pulses.
- `done` is asserted in FIN, i.e. the cycle after the last write grant, or 1 cycle after accept when `len` = 0.
- A new command can be accepted the cycle after `done`.
- Uncontended throughput:
  - Fill: 1 word per cycle.
  - Copy: 4 cycles per word (C_RD, C_W1, C_W2, C_WR).
- The CPU can use the port during C_W1 and C_W2 without delaying the copy.
- Contention: after losing one round-robin decision, a requester waits at most 1 extra cycle.

## Test plan
- **CPU-only traffic:** write 16'hABCD to 0x0100, then read 0x0100 → `cpu_ack` at t+1 for the write; read `cpu_ack` at t+2 with `cpu_rdata` = 16'hABCD.
- **Fill:** src ignored, dst = 0x0000, len = 4, data = 16'h0720 → writes at 0, 2, 4, 6 on consecutive cycles; `done` 1 cycle after the last write; `busy` high for 5 cycles.
- **Scroll copy:** src = 0x00F0, dst = 0x0000, len = 80 over a preloaded pattern → destination matches the source; `done` after 321 cycles with no CPU traffic.
- **Contention:** `cpu_req` held during a fill of len = 4 → grants alternate CPU, engine, CPU, ...; CPU write acked within 2 cycles of request; fill completes.
- **Zero length, then back-to-back commands:** `cmd_len` = 0 → `done` 1 cycle after accept, no `mem_do_write`; then `cmd_valid` held → second command accepted the cycle after `done`.
- **Reset mid-copy:** assert `reset_n` = 0 at word 3 of 10 → all outputs return to their reset values asynchronously; no `done`; the next command runs normally.

Source files
------------

// File: rtl/vga_io_port_arbiter.sv
// Per-access arbiter for the VGA memory io port: CPU vs fill/copy engine, round-robin on conflict.
// CPU write acks at +1 and read at +2. A requester that loses arbitration simply holds its request; it waits at most one cycle.
module vga_io_port_arbiter (
  input  logic        main_clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic        cpu_byte_op,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_copy,
  input  logic [14:0] cmd_src,
  input  logic [14:0] cmd_dst,
  input  logic [13:0] cmd_len,
  input  logic [15:0] cmd_fill_data,
  output logic        busy,
  output logic        done,
  output logic        mem_do_write,
  output logic        mem_do_byte_op,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_data
);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_C_RD = 3'd2;
  localparam logic [2:0] ST_C_W1 = 3'd3;
  localparam logic [2:0] ST_C_W2 = 3'd4;
  localparam logic [2:0] ST_C_WR = 3'd5;
  localparam logic [2:0] ST_FIN  = 3'd6;

  logic [2:0]  r_state;
  logic [13:0] r_src;
  logic [13:0] r_dst;
  logic [13:0] r_len;
  logic [15:0] r_fill;
  logic [15:0] r_hold;
  logic        r_rr_eng_last;
  logic        r_rd_p1;
  logic        r_rd_p2;
  logic        r_wr_p1;

  logic w_cpu_elig;
  logic w_eng_elig;
  logic w_cpu_gnt;
  logic w_eng_gnt;
  logic w_accept;
  logic w_last_word;
  logic w_unused_lsb;

  // Addresses are held as word indices, so the byte LSBs of the command are dropped.
  assign w_unused_lsb = cmd_src[0] ^ cmd_dst[0];

  assign w_cpu_elig  = reset_n & cpu_req & ~(r_rd_p1 | r_rd_p2 | r_wr_p1);
  assign w_eng_elig  = (r_state == ST_FILL) | (r_state == ST_C_RD) | (r_state == ST_C_WR);
  assign w_cpu_gnt   = w_cpu_elig & (~w_eng_elig | r_rr_eng_last);
  assign w_eng_gnt   = w_eng_elig & ~w_cpu_gnt;
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_last_word = (r_len == 14'd1);

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FIN);
  assign cpu_ack   = r_wr_p1 | r_rd_p2;
  assign cpu_rdata = r_rd_p2 ? mem_read_data : 16'h0000;

  always_comb begin
    mem_do_write   = 1'b0;
    mem_do_byte_op = 1'b0;
    mem_addr       = 15'h0000;
    mem_write_data = 16'h0000;
    if (w_cpu_gnt) begin
      mem_do_write   = cpu_write;
      mem_do_byte_op = cpu_byte_op;
      mem_addr       = cpu_addr;
      mem_write_data = cpu_wdata;
    end else if (w_eng_gnt) begin
      mem_do_write = (r_state != ST_C_RD);
      mem_addr     = (r_state == ST_C_RD) ? {r_src, 1'b0} : {r_dst, 1'b0};
      if (r_state == ST_FILL)
        mem_write_data = r_fill;
      else if (r_state == ST_C_WR)
        mem_write_data = r_hold;
    end
  end

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_p1       <= 1'b0;
      r_rd_p2       <= 1'b0;
      r_wr_p1       <= 1'b0;
      r_rr_eng_last <= 1'b1;
    end else begin
      r_rd_p1 <= w_cpu_gnt & ~cpu_write;
      r_rd_p2 <= r_rd_p1;
      r_wr_p1 <= w_cpu_gnt & cpu_write;
      if (w_cpu_gnt)
        r_rr_eng_last <= 1'b0;
      else if (w_eng_gnt)
        r_rr_eng_last <= 1'b1;
    end
  end

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_src   <= 14'h0000;
      r_dst   <= 14'h0000;
      r_len   <= 14'h0000;
      r_fill  <= 16'h0000;
      r_hold  <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_src  <= cmd_src[14:1];
            r_dst  <= cmd_dst[14:1];
            r_len  <= cmd_len;
            r_fill <= cmd_fill_data;
            if (cmd_len == 14'd0)
              r_state <= ST_FIN;
            else if (cmd_copy)
              r_state <= ST_C_RD;
            else
              r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_eng_gnt) begin
            r_dst <= r_dst + 14'd1;
            r_len <= r_len - 14'd1;
            if (w_last_word)
              r_state <= ST_FIN;
          end
        end
        ST_C_RD: begin
          if (w_eng_gnt)
            r_state <= ST_C_W1;
        end
        ST_C_W1: r_state <= ST_C_W2;
        ST_C_W2: begin
          // Read issued in C_RD returns exactly here, two cycles later.
          r_hold  <= mem_read_data;
          r_state <= ST_C_WR;
        end
        ST_C_WR: begin
          if (w_eng_gnt) begin
            r_src   <= r_src + 14'd1;
            r_dst   <= r_dst + 14'd1;
            r_len   <= r_len - 14'd1;
            r_state <= w_last_word ? ST_FIN : ST_C_RD;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
